// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: decode-to-execute pipeline register with a valid/ready
// handshake. It holds up to two entries: main drives the outputs and skid
// catches one extra entry, so the block streams one entry per cycle even when
// out_ready drops. flush clears both entries and zeroes the outputs. stall_cnt
// counts cycles where out_valid=1 and out_ready=0, and it saturates.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is decoded from state only)
//   *_in                decoded instruction payload
//   out_valid/out_ready downstream handshake
//   aluop..raddr2       registered payload (main entry)
//   flush               discard all held entries next edge
//   wb_wen/waddr/wdata  writeback bus, used by the optional forwarding
//   stall_cnt           saturating backpressure-cycle counter
//
// Optional feature: define ID_EXE_WB_FWD_EN so that writeback data is forwarded
// into the rdata1/rdata2 fields of an entry when it is captured and while it is
// held.
module id_exe_pipe_reg #(
  parameter int unsigned DSIZE  = 16,
  parameter int unsigned ASIZE  = 4,
  parameter int unsigned OPSIZE = 3,
  parameter int unsigned CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] aluop_in,
  input  logic              alusrc_in,
  input  logic [DSIZE-1:0]  rdata1_in,
  input  logic [DSIZE-1:0]  rdata2_in,
  input  logic [DSIZE-1:0]  sign_ex_in,
  input  logic [ASIZE-1:0]  waddr_in,
  input  logic [ASIZE-1:0]  raddr1_in,
  input  logic [ASIZE-1:0]  raddr2_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPSIZE-1:0] aluop,
  output logic              alusrc,
  output logic [DSIZE-1:0]  rdata1,
  output logic [DSIZE-1:0]  rdata2,
  output logic [DSIZE-1:0]  sign_ex,
  output logic [ASIZE-1:0]  waddr,
  output logic [ASIZE-1:0]  raddr1,
  output logic [ASIZE-1:0]  raddr2,
  input  logic              flush,
  input  logic              wb_wen,
  input  logic [ASIZE-1:0]  wb_waddr,
  input  logic [DSIZE-1:0]  wb_wdata,
  output logic [CNTW-1:0]   stall_cnt
);

  typedef struct packed {
    logic [OPSIZE-1:0] aluop;
    logic              alusrc;
    logic [DSIZE-1:0]  rdata1;
    logic [DSIZE-1:0]  rdata2;
    logic [DSIZE-1:0]  sign_ex;
    logic [ASIZE-1:0]  waddr;
    logic [ASIZE-1:0]  raddr1;
    logic [ASIZE-1:0]  raddr2;
  } entry_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  entry_t          main_q, main_d, skid_q, skid_d, in_pl;
  logic            main_v, main_v_d, skid_v, skid_v_d;
  logic            accept, drain;
  logic [CNTW-1:0] cnt_q, cnt_d;

`ifdef ID_EXE_WB_FWD_EN
  // Replace an operand with writeback data when its source register is written.
  // Register 0 is never forwarded.
  function automatic entry_t fwd(input entry_t e);
    entry_t r;
    r = e;
    if (wb_wen && (wb_waddr == e.raddr1) && (e.raddr1 != '0)) r.rdata1 = wb_wdata;
    if (wb_wen && (wb_waddr == e.raddr2) && (e.raddr2 != '0)) r.rdata2 = wb_wdata;
    return r;
  endfunction
`else
  function automatic entry_t fwd(input entry_t e);
    return e;
  endfunction

  logic unused_wb;
  assign unused_wb = ^{wb_wen, wb_waddr, wb_wdata};
`endif

  assign in_pl = '{aluop: aluop_in, alusrc: alusrc_in, rdata1: rdata1_in,
                   rdata2: rdata2_in, sign_ex: sign_ex_in, waddr: waddr_in,
                   raddr1: raddr1_in, raddr2: raddr2_in};

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign drain    = main_v & out_ready;

  // Next-state for both entries and the stall counter
  always_comb begin
    main_v_d = main_v;
    skid_v_d = skid_v;
    main_d   = main_v ? fwd(main_q) : main_q;
    skid_d   = skid_v ? fwd(skid_q) : skid_q;
    cnt_d    = cnt_q;

    if (main_v && !out_ready && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNTW'(1);

    if (!main_v || drain) begin
      if (skid_v) begin
        main_d   = fwd(skid_q);
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
        if (accept) begin
          skid_d   = fwd(in_pl);
          skid_v_d = 1'b1;
        end
      end else if (accept) begin
        main_d   = fwd(in_pl);
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = fwd(in_pl);
      skid_v_d = 1'b1;
    end

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = '0;
      skid_d   = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      main_v <= main_v_d;
      skid_v <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = main_v;
  assign aluop     = main_q.aluop;
  assign alusrc    = main_q.alusrc;
  assign rdata1    = main_q.rdata1;
  assign rdata2    = main_q.rdata2;
  assign sign_ex   = main_q.sign_ex;
  assign waddr     = main_q.waddr;
  assign raddr1    = main_q.raddr1;
  assign raddr2    = main_q.raddr2;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- Parametrised decode-to-execute pipeline register with a valid/ready handshake, a skid entry for full throughput under backpressure, flush (bubble insertion) and a saturating stall counter.
- Sits between the register-file/decode logic and the ALU/execute stage.
- Carries ALU control, operands, sign-extended immediate, destination address and source addresses.

Parameters:
- DSIZE, 16, data width of rdata1/rdata2/sign_ex/wb_wdata
- ASIZE, 4, register address width
- OPSIZE, 3, ALU opcode width
- CNTW, 8, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a decoded instruction
- in_ready  out  1  block can accept this cycle
- aluop_in  in  OPSIZE  ALU operation
- alusrc_in  in  1  ALU B-source select (1 = immediate)
- rdata1_in, rdata2_in  in  DSIZE each  register operands
- sign_ex_in  in  DSIZE  sign-extended immediate
- waddr_in  in  ASIZE  destination register
- raddr1_in, raddr2_in  in  ASIZE each  source registers
- out_valid  out  1  output payload valid
- out_ready  in  1  execute stage consumes this cycle
- aluop, alusrc, rdata1, rdata2, sign_ex, waddr, raddr1, raddr2  out  widths as inputs  registered payload
- flush  in  1  discard all held entries
- wb_wen  in  1  writeback enable (used only with the optional feature)
- wb_waddr  in  ASIZE  writeback address
- wb_wdata  in  DSIZE  writeback data
- stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage
  - main entry (drives outputs, flag main_v).
  - skid entry (flag skid_v).
  - out_valid = main_v.
  - in_ready = !skid_v, decoded from registered state only.
- Definitions: accept = in_valid & in_ready; drain = main_v & out_ready.
- Priority per clock edge: rst > flush > normal.
- Normal update when main empty or drain:
  - If skid_v: main <= skid, skid_v <= 0; any accepted input goes to skid.
  - Else if accept: main <= input, main_v <= 1.
  - Else: main_v <= 0; payload holds its last value.
- Normal update when main full and not drain:
  - If accept: skid <= input, skid_v <= 1.
  - Main holds.
- Invariant: skid_v=1 implies main_v=1; the bench asserts this.
- Latency: 1 cycle from accept to out_valid when the block is empty.
- Throughput: one entry per cycle under continuous out_ready.
- Ordering: FIFO; no entry lost or duplicated.
- Flush:
  - Next cycle main_v=0, skid_v=0, all payload fields 0, in_ready=1.
  - An input offered in the flush cycle is dropped.
  - A drain in the flush cycle still counts as consumed downstream.
  - stall_cnt is unaffected.
- Reset:
  - main_v, skid_v, every payload output and stall_cnt = 0.
  - in_ready = 1 from the cycle after reset.
  - Reset mid-operation discards both entries.
- Stall counter:
  - +1 each cycle with main_v & !out_ready.
  - Saturates at 2^CNTW-1 with no wrap.
  - Cleared only by rst.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: ID_EXE_WB_FWD_EN.
- Defined:
  - Match condition: wb_wen=1, wb_waddr equals the entry's raddrX, and raddrX != 0.
  - On capture into main or skid, a match makes rdataX take wb_wdata instead of rdataX_in.
  - While an entry is held in main or skid, a match updates that entry's rdataX to wb_wdata on the next edge.
  - Both operands are checked independently.
  - Flush/rst take priority.
- Undefined:
  - wb_* ports remain but are ignored.
  - rdata fields pass through unchanged.

Test Plan:
- Reset → out_valid=0, payload all 0, in_ready=1, stall_cnt=0; rst asserted with both entries full → same result next cycle.
- Streaming, out_ready=1, in_valid=1, rdata1_in=0x0011,0x0022,0x0033 on consecutive cycles → outputs 0x0011,0x0022,0x0033 one cycle later each; in_ready constant 1; no bubbles.
- Backpressure, entries A,B,C offered, out_ready=0 for 3 cycles → A in main, B in skid, in_ready=0 with C held upstream; release → A,B,C in order, exactly once; stall_cnt=3.
- Flush with main and skid full plus in_valid=1 → next cycle out_valid=0, payload 0, in_ready=1; offered input absent from output.
- Forwarding with ID_EXE_WB_FWD_EN:
  - Held entry raddr1=5, out_ready=0, wb_wen=1, wb_waddr=5, wb_wdata=0xABCD → rdata1=0xABCD next cycle.
  - raddr2=0 with wb_waddr=0 → rdata2 unchanged.
  - Without the macro → rdata1 unchanged.
- Saturation, CNTW=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and holds; flush → stall_cnt still 15.
